// File: rtl/vout_pixel_feeder.sv
//------------------------------------------------------------------------------
// vout_pixel_feeder : FIFO-buffered, SOF-locked pixel source for video output.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vout_pixel_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_sof,
    input  logic [3*DATA_WIDTH-1:0] s_data,
    input  logic                    frame_start,
    input  logic                    pix_req,
    input  logic                    err_clr,
    output logic [DATA_WIDTH-1:0]   datar_o,
    output logic [DATA_WIDTH-1:0]   datag_o,
    output logic [DATA_WIDTH-1:0]   datab_o,
    output logic [DEPTH_LOG2:0]     level_o,
    output logic                    underflow_o,
    output logic                    misalign_o
);

    localparam int PIX_W   = 3 * DATA_WIDTH;
    localparam int ENTRY_W = PIX_W + 1;
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } state_t;

    state_t               state;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0]  wr_ptr;
    logic [DEPTH_LOG2:0]  rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   head;
    logic                 head_sof;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign s_ready  = !full && !rst;
    assign push     = s_valid && s_ready;
    assign head     = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign head_sof = head[ENTRY_W-1];
    assign level_o  = wr_ptr - rd_ptr;

    // SYNC drops non-SOF heads; RUN pops only on a served request.
    always_comb begin
        pop = 1'b0;
        case (state)
            SYNC:    pop = !empty && !head_sof;
            RUN:     pop = pix_req && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_sof, s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            datar_o     <= '0;
            datag_o     <= '0;
            datab_o     <= '0;
            underflow_o <= 1'b0;
            misalign_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (err_clr) begin
                underflow_o <= 1'b0;
                misalign_o  <= 1'b0;
            end

            case (state)
                SYNC: begin
                    {datar_o, datag_o, datab_o} <= '0;
                    if (!empty && head_sof) state <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    {datar_o, datag_o, datab_o} <= '0;
                    if (frame_start) state <= RUN;
                end
                RUN: begin
                    if (pix_req) begin
                        if (empty) {datar_o, datag_o, datab_o} <= '0;
                        else       {datar_o, datag_o, datab_o} <= head[PIX_W-1:0];
                    end
                    // Set events are written last so they override err_clr.
                    if (frame_start && (empty || !head_sof)) begin
                        misalign_o <= 1'b1;
                        state      <= SYNC;
                    end
                    if (pix_req && empty) begin
                        underflow_o <= 1'b1;
                        state       <= SYNC;
                    end
                end
                default: begin
                    {datar_o, datag_o, datab_o} <= '0;
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vout_pixel_feeder.sv
//------------------------------------------------------------------------------
// tb_vout_pixel_feeder : directed self-checking bench for vout_pixel_feeder.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vout_pixel_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic [23:0] s_data;
    logic        frame_start;
    logic        pix_req;
    logic        err_clr;
    logic [7:0]  datar_o;
    logic [7:0]  datag_o;
    logic [7:0]  datab_o;
    logic [4:0]  level_o;
    logic        underflow_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    vout_pixel_feeder #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
        .frame_start(frame_start), .pix_req(pix_req), .err_clr(err_clr),
        .datar_o(datar_o), .datag_o(datag_o), .datab_o(datab_o),
        .level_o(level_o), .underflow_o(underflow_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic sof, input logic [23:0] d);
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    function automatic logic [23:0] pix(input int i);
        logic [7:0] b;
        b = 8'(i * 16);
        return {b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    function automatic logic [31:0] rgb();
        return {8'h00, datar_o, datag_o, datab_o};
    endfunction

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        frame_start = 1'b0; pix_req = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_rgb", rgb(), 32'd0);
        chk("rst_flags", 32'({underflow_o, misalign_o}), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        // Fill: SOF first so SYNC holds it and the FIFO can reach 16.
        for (int i = 0; i < 16; i++) write_px(i == 0, 24'(i + 1));
        chk("full_level", 32'(level_o), 32'd16);
        chk("full_ready", 32'(s_ready), 32'd0);
        write_px(1'b0, 24'h999999);
        chk("full_no_accept", 32'(level_o), 32'd16);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_level", 32'(level_o), 32'd0);

        // Three stale pixels ahead of SOF are discarded.
        write_px(1'b0, 24'hA0A0A0);
        write_px(1'b0, 24'hB0B0B0);
        write_px(1'b0, 24'hC0C0C0);
        write_px(1'b1, 24'h112233);
        tick();
        chk("sync_level", 32'(level_o), 32'd1);
        chk("wait_rgb", rgb(), 32'd0);
        frame_start = 1'b1; pix_req = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("fs_cycle_req_ignored", 32'(level_o), 32'd1);
        tick();
        pix_req = 1'b0;
        chk("first_pixel", rgb(), 32'h112233);
        chk("first_level", 32'(level_o), 32'd0);

        // Steady stream: one write and one request per cycle.
        write_px(1'b0, pix(0));
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1; s_data = pix(i); pix_req = 1'b1;
            tick();
            chk("stream_rgb", rgb(), 32'(pix(i - 1)));
            chk("stream_level", 32'(level_o), 32'd1);
        end
        s_valid = 1'b0;
        tick();
        pix_req = 1'b0;
        chk("stream_last", rgb(), 32'(pix(5)));
        tick();
        chk("hold_rgb", rgb(), 32'(pix(5)));
        chk("stream_flags", 32'({underflow_o, misalign_o}), 32'd0);

        // Underflow and recovery.
        pix_req = 1'b1; tick(); pix_req = 1'b0;
        chk("underflow_set", 32'(underflow_o), 32'd1);
        chk("underflow_rgb", rgb(), 32'd0);
        write_px(1'b1, 24'h445566);
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        pix_req = 1'b1; tick(); pix_req = 1'b0;
        chk("recover_rgb", rgb(), 32'h445566);
        chk("underflow_sticky", 32'(underflow_o), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("underflow_clr", 32'(underflow_o), 32'd0);

        // Misalignment and resync.
        write_px(1'b0, 24'hAAAAAA);
        write_px(1'b0, 24'hBBBBBB);
        write_px(1'b1, 24'h778899);
        write_px(1'b0, 24'hCCCCCC);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("misalign_set", 32'(misalign_o), 32'd1);
        chk("misalign_level0", 32'(level_o), 32'd4);
        tick();
        chk("discard1", 32'(level_o), 32'd3);
        tick();
        chk("discard2", 32'(level_o), 32'd2);
        tick();
        chk("wait_keeps_sof", 32'(level_o), 32'd2);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        pix_req = 1'b1; tick(); pix_req = 1'b0;
        chk("resync_rgb", rgb(), 32'h778899);
        chk("resync_level", 32'(level_o), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("misalign_clr", 32'(misalign_o), 32'd0);
        frame_start = 1'b1; err_clr = 1'b1; pix_req = 1'b1;
        tick();
        frame_start = 1'b0; err_clr = 1'b0; pix_req = 1'b0;
        chk("set_beats_clr", 32'(misalign_o), 32'd1);
        chk("misalign_pop_rgb", rgb(), 32'hCCCCCC);
        chk("misalign_pop_level", 32'(level_o), 32'd0);
        tick();
        chk("sync_rgb_zero", rgb(), 32'd0);

        // Reset mid-frame with nine pixels buffered.
        write_px(1'b1, 24'h0D0E0F);
        for (int i = 1; i <= 9; i++) write_px(1'b0, pix(i));
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        pix_req = 1'b1; tick(); pix_req = 1'b0;
        chk("pre_rst_rgb", rgb(), 32'h0D0E0F);
        chk("pre_rst_level", 32'(level_o), 32'd9);
        rst = 1'b1; tick();
        chk("midrst_rgb", rgb(), 32'd0);
        chk("midrst_level", 32'(level_o), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd0);
        chk("midrst_flags", 32'({underflow_o, misalign_o}), 32'd0);
        rst = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        pix_req = 1'b1; tick(); pix_req = 1'b0;
        chk("post_rst_rgb", rgb(), 32'd0);
        chk("post_rst_level", 32'(level_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
